muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Sequencer and architectural HI/LO owner for the CPU's multiply/divide unit. It accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO operation at a time from the execute stage. Multiplies go to the external combinational 32x32 multiplier, treated as a MULT_LAT-cycle multicycle path. Divides run in an internal iterative divider. The block raises o_busy so the pipeline can stall MFHI/MFLO and further mult/div issue.

## Interface
- MULT_LAT, 3: cycles operands are held stable on the multiplier ports before the product is captured; legal range 1..15.
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- i_start  in  1  issue strobe, sampled at rising edge.
- i_op  in  3  operation: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6/7 reserved, treated as no-op.
- i_opr1  in  32  rs value: multiplicand, dividend, or MTHI/MTLO source.
- i_opr2  in  32  rt value: multiplier or divisor.
- i_flush  in  1  exception/flush: abort any in-flight operation.
- o_mult_opr1  out  32  registered operand to multiplier.
- o_mult_opr2  out  32  registered operand to multiplier.
- o_mult_unsigned  out  1  registered signedness select to multiplier.
- i_mult_hi  in  32  multiplier product bits 63:32.
- i_mult_lo  in  32  multiplier product bits 31:0.
- o_busy  out  1  operation in flight; HI/LO not yet valid.
- o_done  out  1  one-cycle pulse: HI/LO updated at the preceding edge.
- o_hi  out  32  architectural HI register.
- o_lo  out  32  architectural LO register.

## Operation
- States:
  - IDLE: accepts issue.
  - MUL: counts MULT_LAT cycles, then captures the product.
  - DIV: 32 iterations.
  - DFIX: sign fixup and write of HI/LO.
  - After MUL or DFIX, the state returns to IDLE.
- Accepting an issue:
  - Issue is accepted only in IDLE with i_start=1 and i_flush=0.
  - i_start while busy is ignored, with no queueing. The pipeline must not issue while o_busy=1.
- MTHI/MTLO:
  - HI (or LO) <= i_opr1 at the accepting edge.
  - o_done pulses the next cycle. o_busy is never raised.
- MULT/MULTU:
  - Operands and the unsigned flag are latched into the o_mult_* registers, and a counter loads MULT_LAT-1.
  - When the counter reaches 0: HI <= i_mult_hi, LO <= i_mult_lo, state returns to IDLE.
- DIV/DIVU:
  - Absolute values are latched (unsigned: raw values) and passed to div_iter.
  - Restoring radix-2 algorithm, one quotient bit per cycle, 32 cycles.
  - In DFIX, quotient sign = s1^s2 and remainder sign = s1 (signed only). Then HI <= remainder, LO <= quotient.
- Divide by zero: LO <= 0xFFFFFFFF, HI <= i_opr1 original value, with no sign fixup. Timing is the same as a normal divide.
- Overflow: 0x80000000 / 0xFFFFFFFF signed gives LO=0x80000000, HI=0 (natural wrap).
- Flush:
  - Any state goes to IDLE at the next edge. HI/LO are unchanged and no o_done pulse occurs.
  - i_flush has priority over i_start and over a capture in the same cycle.
- Reset: HI=LO=0, o_mult_* = 0, o_busy=0, o_done=0, state IDLE, counters 0.

## Timing
- The accepting edge is T. o_busy is a registered output and rises in the cycle after T.
- Multiply:
  - o_busy=1 during cycles T+1..T+MULT_LAT.
  - HI/LO are written at edge T+MULT_LAT.
  - o_busy=0 and o_done=1 in the following cycle.
  - MULT_LAT=1: one busy cycle.
- Divide: o_busy high for 33 cycles (32 iterations plus DFIX). HI/LO are written at edge T+33, and o_done follows.
- Back-to-back issue: a new issue is accepted in the o_done cycle, since the state is already IDLE.
- o_mult_* stay constant from T+1 until the next accepted multiply. The multiplier inputs never toggle mid-operation.
- o_hi/o_lo change only at a capture edge, an MTHI/MTLO edge, or reset.

## Structure
- Shared package (muldiv_pkg) holds:
  - the op-code localparams;
  - the state enum {IDLE, MUL, DIV, DFIX};
  - DIV_ITER=32.
- Sub-module div_iter: unsigned restoring core.
  - Inputs: start, dividend, divisor. Outputs: quotient, remainder, last-iteration flag.
  - Has its own 6-bit counter and a clear input driven by flush/reset.
- Sign handling, the divide-by-zero override, and HI/LO registers stay in muldiv_ctrl.
- Multiplier is instantiated outside; this block only drives and samples it.

## Test plan
- MULT 0xFFFFFFFE x 0x00000003, MULT_LAT=3 -> o_busy cycles T+1..T+3; HI=0xFFFFFFFF, LO=0xFFFFFFFA; o_done at T+4.
- MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV 0xFFFFFFF9 (-7) / 2 -> after 33 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU 100 / 0 -> LO=0xFFFFFFFF, HI=100. Then DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- MTHI 0x12345678 -> HI updated next cycle, o_busy never high, o_done 1 cycle. Then MULT issued in the o_done cycle is accepted.
- DIV issued, i_flush at cycle T+10 -> o_busy low at T+11, no o_done, HI/LO unchanged.
- Reset asserted mid-divide -> all outputs 0 next cycle.
- i_start while busy is ignored.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer: op codes, FSM states,
// divider iteration count and a conditional-negate helper.
package muldiv_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;

    localparam int DIV_ITER = 32;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DFIX} state_t;

    function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_div_iter.sv
// Unsigned restoring divider: one quotient bit per clock, DIV_ITER clocks after start.
// The quotient register starts holding the dividend and shifts it out MSB first.
module div_iter
    import muldiv_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        last
);

    logic [5:0]  cnt;
    logic        running;
    logic [31:0] dvs;
    logic [32:0] shifted;
    logic        fits;

    assign shifted = {remainder, quotient[31]};
    assign fits    = shifted >= {1'b0, dvs};
    assign last    = running && (cnt == 6'(DIV_ITER - 1));

    always_ff @(posedge clk) begin
        if (clear) begin
            running   <= 1'b0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            dvs       <= '0;
        end else if (start) begin
            running   <= 1'b1;
            cnt       <= '0;
            quotient  <= dividend;
            remainder <= '0;
            dvs       <= divisor;
        end else if (running) begin
            remainder <= fits ? 32'(shifted - {1'b0, dvs}) : shifted[31:0];
            quotient  <= {quotient[30:0], fits};
            cnt       <= last ? 6'd0 : cnt + 6'd1;
            if (last)
                running <= 1'b0;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer owning architectural HI/LO. Multiplies use an external
// combinational multiplier as a MULT_LAT-cycle path; divides use div_iter.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MULT_LAT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_start,
    input  logic [2:0]  i_op,
    input  logic [31:0] i_opr1,
    input  logic [31:0] i_opr2,
    input  logic        i_flush,
    output logic [31:0] o_mult_opr1,
    output logic [31:0] o_mult_opr2,
    output logic        o_mult_unsigned,
    input  logic [31:0] i_mult_hi,
    input  logic [31:0] i_mult_lo,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    localparam logic [3:0] CNT_INIT = 4'(MULT_LAT - 1);

    state_t      state, state_n;
    logic [3:0]  cnt;
    logic        mul_go, mul_cap, div_go, div_wr, mt_hi, mt_lo;
    logic        s_q, s_r, dz;
    logic [31:0] dvd_orig;
    logic        div_signed;
    logic [31:0] quo, rem;
    logic        div_last;

    assign div_signed = (i_op == OP_DIV);

    div_iter u_div (
        .clk       (clk),
        .clear     (reset | i_flush),
        .start     (div_go),
        .dividend  (neg_if(div_signed && i_opr1[31], i_opr1)),
        .divisor   (neg_if(div_signed && i_opr2[31], i_opr2)),
        .quotient  (quo),
        .remainder (rem),
        .last      (div_last)
    );

    // Flush wins over issue and over a same-cycle capture.
    always_comb begin
        state_n = state;
        mul_go  = 1'b0;
        mul_cap = 1'b0;
        div_go  = 1'b0;
        div_wr  = 1'b0;
        mt_hi   = 1'b0;
        mt_lo   = 1'b0;
        if (i_flush) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (i_start) begin
                    case (i_op)
                        OP_MULT, OP_MULTU: begin state_n = MUL; mul_go = 1'b1; end
                        OP_DIV,  OP_DIVU:  begin state_n = DIV; div_go = 1'b1; end
                        OP_MTHI: mt_hi = 1'b1;
                        OP_MTLO: mt_lo = 1'b1;
                        default: ;
                    endcase
                end
                MUL: if (cnt == 4'd0) begin
                    mul_cap = 1'b1;
                    state_n = IDLE;
                end
                DIV: if (div_last) state_n = DFIX;
                DFIX: begin
                    div_wr  = 1'b1;
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            o_busy          <= 1'b0;
            o_done          <= 1'b0;
            o_hi            <= '0;
            o_lo            <= '0;
            o_mult_opr1     <= '0;
            o_mult_opr2     <= '0;
            o_mult_unsigned <= 1'b0;
            s_q             <= 1'b0;
            s_r             <= 1'b0;
            dz              <= 1'b0;
            dvd_orig        <= '0;
        end else begin
            state  <= state_n;
            o_busy <= (state_n != IDLE);
            o_done <= mul_cap | div_wr | mt_hi | mt_lo;
            if (mul_go) begin
                o_mult_opr1     <= i_opr1;
                o_mult_opr2     <= i_opr2;
                o_mult_unsigned <= (i_op == OP_MULTU);
                cnt             <= CNT_INIT;
            end else if (state == MUL && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (div_go) begin
                s_q      <= div_signed && (i_opr1[31] ^ i_opr2[31]);
                s_r      <= div_signed && i_opr1[31];
                dz       <= (i_opr2 == 32'd0);
                dvd_orig <= i_opr1;
            end
            if (mt_hi) o_hi <= i_opr1;
            if (mt_lo) o_lo <= i_opr1;
            if (mul_cap) begin
                o_hi <= i_mult_hi;
                o_lo <= i_mult_lo;
            end
            // Divide by zero skips sign fixup: LO all ones, HI the raw dividend.
            if (div_wr) begin
                o_hi <= dz ? dvd_orig     : neg_if(s_r, rem);
                o_lo <= dz ? 32'hFFFFFFFF : neg_if(s_q, quo);
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Bench for muldiv_ctrl: transaction-level model with per-cycle compare, directed
// literal cases, then randomized issue/flush/reset traffic.
module tb_muldiv_ctrl;

    localparam int MULT_LAT = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_start = 1'b0;
    logic [2:0]  i_op = 3'd0;
    logic [31:0] i_opr1 = '0, i_opr2 = '0;
    logic        i_flush = 1'b0;
    logic [31:0] o_mult_opr1, o_mult_opr2;
    logic        o_mult_unsigned;
    logic [31:0] i_mult_hi, i_mult_lo;
    logic        o_busy, o_done;
    logic [31:0] o_hi, o_lo;

    int n_tests = 0;
    int n_fail  = 0;

    muldiv_ctrl #(.MULT_LAT(MULT_LAT)) dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_op(i_op),
        .i_opr1(i_opr1), .i_opr2(i_opr2), .i_flush(i_flush),
        .o_mult_opr1(o_mult_opr1), .o_mult_opr2(o_mult_opr2),
        .o_mult_unsigned(o_mult_unsigned),
        .i_mult_hi(i_mult_hi), .i_mult_lo(i_mult_lo),
        .o_busy(o_busy), .o_done(o_done), .o_hi(o_hi), .o_lo(o_lo)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] prod(input logic u, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        if (u) return {32'd0, a} * {32'd0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        return 64'(sa * sb);
    endfunction

    // External combinational multiplier.
    assign {i_mult_hi, i_mult_lo} = prod(o_mult_unsigned, o_mult_opr1, o_mult_opr2);

    // Reference model: a pending result plus a count of busy cycles left.
    logic [31:0] m_hi = '0, m_lo = '0, m_pend_hi = '0, m_pend_lo = '0;
    logic [31:0] m_mop1 = '0, m_mop2 = '0;
    logic        m_mu = 1'b0, m_done = 1'b0;
    int          m_left = 0;

    always @(posedge clk) begin
        longint sa, sb;
        logic [63:0] p;
        m_done = 1'b0;
        if (reset) begin
            m_hi = '0; m_lo = '0; m_mop1 = '0; m_mop2 = '0; m_mu = 1'b0; m_left = 0;
        end else if (i_flush) begin
            m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_hi = m_pend_hi; m_lo = m_pend_lo; m_done = 1'b1;
            end
        end else if (i_start) begin
            case (i_op)
                3'd0, 3'd1: begin
                    m_mop1 = i_opr1; m_mop2 = i_opr2; m_mu = (i_op == 3'd1);
                    p = prod(m_mu, i_opr1, i_opr2);
                    m_pend_hi = p[63:32]; m_pend_lo = p[31:0];
                    m_left = MULT_LAT;
                end
                3'd2, 3'd3: begin
                    if (i_opr2 == 0) begin
                        m_pend_lo = 32'hFFFFFFFF; m_pend_hi = i_opr1;
                    end else begin
                        sa = (i_op == 3'd2) ? longint'($signed(i_opr1)) : longint'(i_opr1);
                        sb = (i_op == 3'd2) ? longint'($signed(i_opr2)) : longint'(i_opr2);
                        m_pend_lo = 32'(sa / sb);
                        m_pend_hi = 32'(sa % sb);
                    end
                    m_left = 33;
                end
                3'd4: begin m_hi = i_opr1; m_done = 1'b1; end
                3'd5: begin m_lo = i_opr1; m_done = 1'b1; end
                default: ;
            endcase
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one cycle and compare every output against the model.
    task automatic tick();
        @(negedge clk);
        chk("busy", 32'(o_busy), 32'(m_left > 0));
        chk("done", 32'(o_done), 32'(m_done));
        chk("hi", o_hi, m_hi);
        chk("lo", o_lo, m_lo);
        chk("mopr1", o_mult_opr1, m_mop1);
        chk("mopr2", o_mult_opr2, m_mop2);
        chk("munsigned", 32'(o_mult_unsigned), 32'(m_mu));
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        i_start = 1'b1; i_op = op; i_opr1 = a; i_opr2 = b;
        tick();
        i_start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_busy,
                             input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n = 0;
        bit seen = 0;
        for (int k = 0; k < 60; k++) begin
            if (o_done) begin seen = 1; break; end
            if (o_busy) n++;
            tick();
        end
        chk({name, "_done_seen"}, 32'(seen), 32'd1);
        chk({name, "_busy_cycles"}, 32'(n), 32'(exp_busy));
        chk({name, "_hi"}, o_hi, exp_hi);
        chk({name, "_lo"}, o_lo, exp_lo);
    endtask

    function automatic logic [31:0] rnd_opr();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        chk("rst_hi", o_hi, 32'd0);
        chk("rst_lo", o_lo, 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);

        issue(3'd0, 32'hFFFFFFFE, 32'd3);
        wait_done("mult", 3, 32'hFFFFFFFF, 32'hFFFFFFFA);
        tick();
        issue(3'd1, 32'hFFFFFFFE, 32'd3);
        wait_done("multu", 3, 32'h00000002, 32'hFFFFFFFA);
        chk("multu_opr", o_mult_opr1, 32'hFFFFFFFE);
        tick();
        issue(3'd2, 32'hFFFFFFF9, 32'd2);
        wait_done("div_neg7", 33, 32'hFFFFFFFF, 32'hFFFFFFFD);
        tick();
        issue(3'd3, 32'd100, 32'd0);
        wait_done("divu_zero", 33, 32'd100, 32'hFFFFFFFF);
        tick();
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF);
        wait_done("div_ovf", 33, 32'd0, 32'h80000000);
        tick();
        issue(3'd4, 32'h12345678, 32'd0);
        wait_done("mthi", 0, 32'h12345678, 32'h80000000);
        issue(3'd0, 32'd5, 32'd7);   // issued in the o_done cycle
        wait_done("b2b_mult", 3, 32'd0, 32'd35);
        tick();

        // MTLO held high while a divide is busy must be ignored.
        issue(3'd3, 32'd50, 32'd7);
        i_start = 1'b1; i_op = 3'd5; i_opr1 = 32'hDEAD;
        for (int k = 0; k < 5; k++) tick();
        i_start = 1'b0;
        wait_done("busy_ignore", 28, 32'd1, 32'd7);
        tick();

        issue(3'd2, 32'd1000, 32'd3);
        for (int k = 0; k < 8; k++) tick();
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        chk("flush_busy", 32'(o_busy), 32'd0);
        for (int k = 0; k < 40; k++) tick();
        chk("flush_hi", o_hi, 32'd1);
        chk("flush_lo", o_lo, 32'd7);

        issue(3'd2, 32'd77, 32'd5);
        for (int k = 0; k < 5; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_hi", o_hi, 32'd0);
        chk("midrst_lo", o_lo, 32'd0);
        chk("midrst_busy", 32'(o_busy), 32'd0);
        chk("midrst_mopr1", o_mult_opr1, 32'd0);

        for (int k = 0; k < 4000; k++) begin
            i_start = ($urandom_range(0, 3) == 0);
            i_op    = 3'($urandom_range(0, 7));
            i_opr1  = rnd_opr();
            i_opr2  = rnd_opr();
            i_flush = ($urandom_range(0, 63) == 0);
            reset   = ($urandom_range(0, 511) == 0);
            tick();
        end
        i_start = 1'b0; i_flush = 1'b0; reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
